// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl
//   Clock-enable controller for the processor core. Produces a registered,
//   single-cycle enable (cpu_en) for the pipeline registers. It supports four
//   modes: free run, single step, N-step burst and run-to-breakpoint. The raw
//   step button is synchronised and debounced here.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-low reset
//   clk_step     raw step button (asynchronous to clk)
//   clk_select   mode: 00 run, 01 step, 10 burst, 11 run-to-breakpoint
//   div          one enable every div+1 cycles in run-type states
//   burst_len    number of enables issued per burst
//   pc           current fetch PC from the core
//   bp_addr      breakpoint address
//   bp_en        breakpoint compare enable
//   cpu_en       registered core clock-enable pulse
//   busy         high in RUN, BURST and BPRUN
//   halted       high in HALT (breakpoint hit)
//   cycle_count  number of cpu_en pulses issued, saturating at all-ones
module cpu_clk_ctrl #(
  parameter int DIV_W        = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int BURST_W      = 8,
  parameter int PC_W         = 32,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_step,
  input  logic [1:0]         clk_select,
  input  logic [DIV_W-1:0]   div,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [PC_W-1:0]    pc,
  input  logic [PC_W-1:0]    bp_addr,
  input  logic               bp_en,
  output logic               cpu_en,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam int DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_BURST,
    S_BPRUN,
    S_HALT
  } state_t;

  state_t             state_reg, state_next;
  logic               step_sync1_reg, step_sync2_reg;
  logic [DEB_W-1:0]   deb_cnt_reg;
  logic               deb_level_reg;
  logic               step_evt_reg;
  logic [DIV_W-1:0]   div_cnt_reg;
  logic [BURST_W-1:0] remaining_reg, remaining_next;
  logic [1:0]         mode_q_reg;
  logic               skip_bp_reg, skip_bp_next;
  logic               cpu_en_reg, cpu_en_next;
  logic [CNT_W-1:0]   count_reg;

  logic run_type;
  logic tick;
  logic mode_chg;
  logic bp_hit;

  assign run_type = (state_reg == S_RUN) || (state_reg == S_BURST) || (state_reg == S_BPRUN);
  assign tick     = run_type && (div_cnt_reg == div);
  assign mode_chg = (clk_select != mode_q_reg);
  assign bp_hit   = bp_en && (pc == bp_addr);

  // Step button: two-flop synchroniser, then a debouncer that only accepts a
  // level after it has differed from the accepted level for DEBOUNCE_CYC
  // consecutive cycles. step_evt_reg pulses once on an accepted rising level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_sync1_reg <= 1'b0;
      step_sync2_reg <= 1'b0;
      deb_cnt_reg    <= '0;
      deb_level_reg  <= 1'b0;
      step_evt_reg   <= 1'b0;
    end else begin
      step_sync1_reg <= clk_step;
      step_sync2_reg <= step_sync1_reg;
      step_evt_reg   <= 1'b0;
      if (step_sync2_reg != deb_level_reg) begin
        if (deb_cnt_reg == DEB_LAST) begin
          deb_level_reg <= step_sync2_reg;
          deb_cnt_reg   <= '0;
          step_evt_reg  <= step_sync2_reg;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + 1'b1;
        end
      end else begin
        deb_cnt_reg <= '0;
      end
    end
  end

  // Rate divider: restarts from zero on every state change so the first tick
  // always lands div+1 cycles after entering a run-type state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_reg <= '0;
    end else if ((state_next != state_reg) || !run_type || tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      remaining_reg <= '0;
      mode_q_reg    <= 2'b00;
      skip_bp_reg   <= 1'b0;
      cpu_en_reg    <= 1'b0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      mode_q_reg    <= clk_select;
      skip_bp_reg   <= skip_bp_next;
      cpu_en_reg    <= cpu_en_next;
      // Counts alongside cpu_en so the count already includes a visible pulse.
      if (cpu_en_next && (count_reg != {CNT_W{1'b1}})) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  // A mode change always wins over a tick or step event in the same cycle.
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    skip_bp_next   = skip_bp_reg;
    cpu_en_next    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // While clk_select is still settling into mode_q, hold off so the new
        // mode is acted on one cycle later and this cycle's step is dropped.
        if (!mode_chg) begin
          case (clk_select)
            2'b00: state_next = S_RUN;
            2'b01: cpu_en_next = step_evt_reg;
            2'b10: begin
              if (step_evt_reg && (burst_len != '0)) begin
                remaining_next = burst_len;
                state_next     = S_BURST;
              end
            end
            default: begin
              if (step_evt_reg) begin
                skip_bp_next = 1'b0;
                state_next   = S_BPRUN;
              end
            end
          endcase
        end
      end
      S_RUN: begin
        if (mode_chg) begin
          state_next = S_IDLE;
        end else if (tick) begin
          cpu_en_next = 1'b1;
        end
      end
      S_BURST: begin
        if (mode_chg) begin
          remaining_next = '0;
          state_next     = S_IDLE;
        end else if (tick) begin
          cpu_en_next    = 1'b1;
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == BURST_W'(1)) begin
            state_next = S_IDLE;
          end
        end
      end
      S_BPRUN: begin
        if (mode_chg) begin
          skip_bp_next = 1'b0;
          state_next   = S_IDLE;
        end else if (tick) begin
          // After a resume the first tick steps past the breakpoint address.
          skip_bp_next = 1'b0;
          if (bp_hit && !skip_bp_reg) begin
            state_next = S_HALT;
          end else begin
            cpu_en_next = 1'b1;
          end
        end
      end
      S_HALT: begin
        if (mode_chg) begin
          state_next = S_IDLE;
        end else if (step_evt_reg) begin
          skip_bp_next = 1'b1;
          state_next   = S_BPRUN;
        end
      end
      default: begin
        remaining_next = '0;
        skip_bp_next   = 1'b0;
        state_next     = S_IDLE;
      end
    endcase
  end

  assign cpu_en      = cpu_en_reg;
  assign busy        = run_type;
  assign halted      = (state_reg == S_HALT);
  assign cycle_count = count_reg;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Testbench for cpu_clk_ctrl. Stimulus pushes expected pulse cycles and
// cycle-tagged state checks into queues; a monitor on the falling edge pops
// and compares them whenever the DUT asserts cpu_en or a check falls due.
module tb_cpu_clk_ctrl;

  localparam int K_EN     = 0;
  localparam int K_BUSY   = 1;
  localparam int K_HALT   = 2;
  localparam int K_CNT    = 3;
  localparam int K_SATCNT = 4;
  localparam int K_SATEN  = 5;
  localparam int K_QEMPTY = 6;

  logic        clk        = 1'b0;
  logic        rst        = 1'b0;
  logic        clk_step   = 1'b0;
  logic [1:0]  clk_select = 2'b01;
  logic [3:0]  div        = 4'd0;
  logic [7:0]  burst_len  = 8'd0;
  logic [31:0] pc         = 32'd0;
  logic [31:0] bp_addr    = 32'd0;
  logic        bp_en      = 1'b0;
  logic        cpu_en, busy, halted;
  logic [31:0] cycle_count;

  // Second instance with a 3-bit counter to exercise saturation.
  logic        sat_step   = 1'b0;
  logic [1:0]  sat_select = 2'b00;
  logic [3:0]  sat_div    = 4'd0;
  logic [7:0]  sat_burst  = 8'd0;
  logic [31:0] sat_pc     = 32'd0;
  logic [31:0] sat_bp     = 32'd0;
  logic        sat_bp_en  = 1'b0;
  logic        sat_en, sat_busy, sat_halted;
  logic [2:0]  sat_count;

  cpu_clk_ctrl #(.DIV_W(4), .DEBOUNCE_CYC(16), .BURST_W(8), .PC_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .clk_step(clk_step), .clk_select(clk_select), .div(div),
    .burst_len(burst_len), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .cpu_en(cpu_en), .busy(busy), .halted(halted), .cycle_count(cycle_count)
  );

  cpu_clk_ctrl #(.DIV_W(4), .DEBOUNCE_CYC(1), .BURST_W(8), .PC_W(32), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .clk_step(sat_step), .clk_select(sat_select), .div(sat_div),
    .burst_len(sat_burst), .pc(sat_pc), .bp_addr(sat_bp), .bp_en(sat_bp_en),
    .cpu_en(sat_en), .busy(sat_busy), .halted(sat_halted), .cycle_count(sat_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Minimal core model: PC advances by 4 after each enable.
  bit core_on = 1'b0;
  always @(negedge clk) begin
    if (!core_on) pc = 32'd0;
    else if (cpu_en) pc = pc + 32'd4;
  end

  typedef struct {
    int     cyc;
    int     kind;
    longint val;
  } chk_t;

  chk_t   chk_q[$];
  int     exp_q[$];
  int     errors    = 0;
  int     checks    = 0;
  int     mon_count = 0;
  int     exp_cyc;

  function automatic void cmp(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      mon_count = 0;
    end else if (cpu_en) begin
      mon_count++;
      if (exp_q.size() == 0) begin
        cmp("unexpected_pulse", cpu_en, 0);
      end else begin
        exp_cyc = exp_q.pop_front();
        cmp("pulse_cycle", cyc, exp_cyc);
      end
      cmp("pulse_count", cycle_count, mon_count);
    end
    for (int i = chk_q.size() - 1; i >= 0; i--) begin
      if (chk_q[i].cyc == cyc) begin
        case (chk_q[i].kind)
          K_EN:     cmp("cpu_en", cpu_en, chk_q[i].val);
          K_BUSY:   cmp("busy", busy, chk_q[i].val);
          K_HALT:   cmp("halted", halted, chk_q[i].val);
          K_CNT:    cmp("cycle_count", cycle_count, chk_q[i].val);
          K_SATCNT: cmp("sat_count", sat_count, chk_q[i].val);
          K_SATEN:  cmp("sat_en", sat_en, chk_q[i].val);
          default:  cmp("pending_pulses", exp_q.size(), chk_q[i].val);
        endcase
        chk_q.delete(i);
      end
    end
  end

  task automatic step_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at(input int c, input int k, input longint v);
    chk_t t;
    t.cyc  = c;
    t.kind = k;
    t.val  = v;
    chk_q.push_back(t);
  endtask

  task automatic pulse_at(input int c);
    exp_q.push_back(c);
  endtask

  int p, b, x, l, q, r;

  initial begin
    // Reset state, then release; the saturating instance free-runs at div=0.
    step_cyc(3);
    at(cyc, K_EN, 0); at(cyc, K_BUSY, 0); at(cyc, K_HALT, 0);
    at(cyc, K_CNT, 0); at(cyc, K_SATCNT, 0);
    rst = 1'b1;
    at(cyc + 7, K_SATCNT, 6);
    at(cyc + 8, K_SATCNT, 7);
    at(cyc + 11, K_SATCNT, 7);
    at(cyc + 11, K_SATEN, 1);
    step_cyc(20);

    // Free run, div=3: ten pulses every 4th cycle after entry.
    div = 4'd3; clk_select = 2'b00; x = cyc + 2;
    for (int k = 1; k <= 10; k++) pulse_at(x + 4 * k);
    at(x, K_BUSY, 1);
    step_cyc(42);
    clk_select = 2'b01;
    at(cyc + 1, K_BUSY, 0); at(cyc + 1, K_CNT, 10);
    step_cyc(10);

    // Single step with a bouncing button: one pulse 19 cycles after last edge.
    for (int k = 0; k < 10; k++) begin
      clk_step = ~clk_step;
      step_cyc(1);
    end
    clk_step = 1'b1; l = cyc;
    pulse_at(l + 19);
    at(l + 19, K_CNT, 11); at(l + 20, K_EN, 0);
    step_cyc(25); clk_step = 1'b0; step_cyc(25);

    // Burst of 6 at div=0: back-to-back pulses, then IDLE.
    clk_select = 2'b10; burst_len = 8'd6; div = 4'd0; step_cyc(3);
    clk_step = 1'b1; p = cyc; b = p + 19;
    for (int k = 1; k <= 6; k++) pulse_at(b + k);
    at(b + 1, K_BUSY, 1); at(b + 6, K_BUSY, 0); at(b + 6, K_CNT, 17);
    step_cyc(20); clk_step = 1'b0; step_cyc(20);

    // Burst of 6 at div=7 with a second step event mid-burst: still 6 pulses.
    div = 4'd7; clk_step = 1'b1; p = cyc; b = p + 19;
    for (int k = 1; k <= 6; k++) pulse_at(b + 8 * k);
    at(b + 39, K_BUSY, 1); at(b + 48, K_BUSY, 0); at(b + 48, K_CNT, 23);
    step_cyc(20); clk_step = 1'b0; step_cyc(20);
    clk_step = 1'b1;
    step_cyc(20); clk_step = 1'b0; step_cyc(20);

    // burst_len=0: the step event is ignored.
    burst_len = 8'd0; clk_step = 1'b1; p = cyc;
    at(p + 20, K_BUSY, 0); at(p + 22, K_CNT, 23);
    step_cyc(20); clk_step = 1'b0; step_cyc(20);

    // Run to breakpoint at 0x20 with div=1, then resume past it.
    div = 4'd1; bp_addr = 32'h20; bp_en = 1'b1; core_on = 1'b1;
    clk_select = 2'b11; step_cyc(3);
    clk_step = 1'b1; p = cyc; b = p + 19;
    for (int k = 1; k <= 8; k++) pulse_at(b + 2 * k);
    at(b + 17, K_HALT, 0); at(b + 17, K_BUSY, 1);
    at(b + 18, K_HALT, 1); at(b + 18, K_BUSY, 0); at(b + 18, K_CNT, 31);
    step_cyc(20); clk_step = 1'b0; step_cyc(25);
    at(cyc, K_HALT, 1);
    clk_step = 1'b1; q = cyc; r = q + 19;
    for (int k = 0; k < 4; k++) pulse_at(r + 2 + 2 * k);
    at(r, K_HALT, 0); at(r, K_BUSY, 1);
    step_cyc(27);
    clk_select = 2'b01;
    at(r + 9, K_BUSY, 0); at(r + 9, K_HALT, 0); at(r + 9, K_CNT, 35);
    step_cyc(5); clk_step = 1'b0; step_cyc(25);
    core_on = 1'b0; bp_en = 1'b0;

    // Mode 10 -> 00 with 3 enables left: one idle cycle, then RUN.
    clk_select = 2'b10; burst_len = 8'd6; div = 4'd0; step_cyc(3);
    clk_step = 1'b1; p = cyc; b = p + 19;
    for (int k = 1; k <= 3; k++) pulse_at(b + k);
    step_cyc(22);
    clk_select = 2'b00;
    at(b + 4, K_EN, 0); at(b + 4, K_BUSY, 0); at(b + 5, K_BUSY, 1);
    for (int k = 6; k <= 8; k++) pulse_at(b + k);
    step_cyc(5);
    clk_select = 2'b01;
    at(b + 9, K_BUSY, 0); at(b + 9, K_CNT, 41);
    step_cyc(5); clk_step = 1'b0; step_cyc(25);

    // Async reset mid-burst (remaining=5): outputs clear at once, stay idle.
    clk_select = 2'b10; div = 4'd3; step_cyc(3);
    clk_step = 1'b1; p = cyc; b = p + 19;
    pulse_at(b + 4);
    at(b + 4, K_BUSY, 1);
    step_cyc(20); clk_step = 1'b0;
    step_cyc(4);
    rst = 1'b0;
    at(cyc, K_EN, 0); at(cyc, K_BUSY, 0); at(cyc, K_HALT, 0); at(cyc, K_CNT, 0);
    step_cyc(3); rst = 1'b1;
    at(cyc + 2, K_BUSY, 0);
    step_cyc(40);
    at(cyc, K_CNT, 0); at(cyc, K_BUSY, 0); at(cyc, K_QEMPTY, 0);
    step_cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
